// File: rtl/cr16_isa_pkg.sv
// Shared CR16-style ISA constants and the host-field -> 16-bit instruction encoder.
package cr16_isa_pkg;

    // Opcode field [15:12]
    localparam logic [3:0] OP_REGISTER = 4'b0000;
    localparam logic [3:0] OP_ADDI     = 4'b0101;
    localparam logic [3:0] OP_SPECIAL  = 4'b0100;
    localparam logic [3:0] OP_MOVI     = 4'b1101;
    localparam logic [3:0] OP_BCOND    = 4'b1100;

    // SPECIAL-group function codes [7:4]
    localparam logic [3:0] FN_LOAD  = 4'b0000;
    localparam logic [3:0] FN_STOR  = 4'b0100;
    localparam logic [3:0] FN_JAL   = 4'b1000;
    localparam logic [3:0] FN_JCOND = 4'b1100;
    localparam logic [3:0] FN_SCOND = 4'b1101;

    // Reg-op with func 0 and no writeback: safe filler between injected words
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FMT_RR    = 2'b00,
        FMT_RI    = 2'b01,
        FMT_SCOND = 2'b10,
        FMT_RSVD  = 2'b11
    } fmt_e;

    typedef struct packed {
        fmt_e       fmt;
        logic [3:0] oper;
        logic [3:0] dst;
        logic [3:0] func;
        logic [3:0] src;
        logic [7:0] imm;
    } host_fields_t;

    // Reserved format yields NOP; the caller is expected to suppress the push.
    function automatic logic [15:0] encode_instr(input host_fields_t f);
        logic [15:0] w;
        w = NOP_INSTR;
        case (f.fmt)
            FMT_RR:    w = {f.oper, f.dst, f.func, f.src};
            FMT_RI:    w = {f.oper, f.dst, f.imm};
            FMT_SCOND: w = {OP_SPECIAL, f.dst, FN_SCOND, f.src};
            default:   w = NOP_INSTR;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inj_fifo.sv
// 16-bit FIFO with explicit level counter so full/empty never alias.
module inj_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [15:0]       wdata,
    input  logic              pop,
    output logic [15:0]       rdata,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    logic [DEPTH-1:0][15:0] mem_q, mem_d;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        level_q, level_d;
    logic                   push_ok, pop_ok;

    assign full    = (level_q == (ADDR_W+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;  // power-of-two depth wraps for free
        end
        if (pop_ok)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level 0 makes stale contents unreachable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_injector.sv
// Packs host instruction fields into ISA words and injects them on pcwrite boundaries.
// Optional INJ_RETIRE_COUNT_EN adds retire_cnt: count of pulses that popped a queued word.
module instr_injector
    import cr16_isa_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [3:0]        in_oper,
    input  logic [3:0]        in_dst,
    input  logic [3:0]        in_func,
    input  logic [3:0]        in_src,
    input  logic [7:0]        in_imm,
    input  logic              inj_mode,
    input  logic [15:0]       mem_instr,
    input  logic              pc_advance,
    output logic [15:0]       instr_out,
`ifdef INJ_RETIRE_COUNT_EN
    output logic [15:0]       retire_cnt,
`endif
    output logic [ADDR_W:0]   fifo_level,
    output logic              inj_active,
    output logic              fmt_err
);

    host_fields_t fields;
    logic [15:0]  enc_word, head;
    logic         hs, push, pop, full, empty;
    logic         mode_q, mode_d;
    logic [15:0]  cur_q, cur_d;
    logic         fmt_err_q, fmt_err_d;

    assign fields = '{fmt: fmt_e'(in_fmt), oper: in_oper, dst: in_dst,
                      func: in_func, src: in_src, imm: in_imm};
    assign enc_word = encode_instr(fields);

    // Reserved format still completes the handshake; only the write is dropped.
    assign hs   = in_valid && in_ready;
    assign push = hs && (fields.fmt != FMT_RSVD);
    assign pop  = pc_advance && inj_mode && !empty;

    inj_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        mode_d    = mode_q;
        cur_d     = cur_q;
        fmt_err_d = fmt_err_q;
        if (pc_advance) begin
            mode_d = inj_mode;
            cur_d  = pop ? head : NOP_INSTR;
        end
        if (hs && fields.fmt == FMT_RSVD)
            fmt_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q    <= 1'b0;
            cur_q     <= NOP_INSTR;
            fmt_err_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            cur_q     <= cur_d;
            fmt_err_q <= fmt_err_d;
        end
    end

`ifdef INJ_RETIRE_COUNT_EN
    logic [15:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (pop)
            retire_cnt_d = retire_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) retire_cnt_q <= '0;
        else      retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`endif

    assign in_ready   = !full;
    assign inj_active = mode_q;
    assign fmt_err    = fmt_err_q;
    // Registered mode keeps the mux steady across multi-cycle instructions.
    assign instr_out  = mode_q ? cur_q : mem_instr;

endmodule

// File: tb/tb_instr_injector.sv
// Self-checking bench for instr_injector: directed plan scenarios plus a randomized run against a queue model.
module tb_instr_injector;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_fmt;
    logic [3:0]        in_oper, in_dst, in_func, in_src;
    logic [7:0]        in_imm;
    logic              inj_mode;
    logic [15:0]       mem_instr;
    logic              pc_advance;
    logic [15:0]       instr_out;
    logic [ADDR_W:0]   fifo_level;
    logic              inj_active;
    logic              fmt_err;
`ifdef INJ_RETIRE_COUNT_EN
    logic [15:0]       retire_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] m_q[$];
    logic        m_mode;
    logic [15:0] m_cur;
    logic        m_err;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    instr_injector #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_oper    (in_oper),
        .in_dst     (in_dst),
        .in_func    (in_func),
        .in_src     (in_src),
        .in_imm     (in_imm),
        .inj_mode   (inj_mode),
        .mem_instr  (mem_instr),
        .pc_advance (pc_advance),
        .instr_out  (instr_out),
`ifdef INJ_RETIRE_COUNT_EN
        .retire_cnt (retire_cnt),
`endif
        .fifo_level (fifo_level),
        .inj_active (inj_active),
        .fmt_err    (fmt_err)
    );

    function automatic logic [15:0] model_encode(input logic [1:0] f, input logic [3:0] op,
            input logic [3:0] d, input logic [3:0] fn, input logic [3:0] s, input logic [7:0] im);
        if (f == 2'd0) return {op, d, fn, s};
        if (f == 2'd1) return {op, d, im};
        return {4'h4, d, 4'hD, s};
    endfunction

    // Advance the model with the inputs as they stand, then clock the DUT.
    task automatic tick();
        bit accept;
        accept = in_valid && (m_q.size() != DEPTH);
        if (!rst) begin
            m_q.delete(); m_mode = 0; m_cur = 16'h0; m_err = 0; m_cnt = 0;
        end else begin
            if (pc_advance) begin
                m_mode = inj_mode;
                if (inj_mode && m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_cnt = m_cnt + 16'd1;
                end else begin
                    m_cur = 16'h0;
                end
            end
            if (accept) begin
                if (in_fmt == 2'd3) m_err = 1;
                else m_q.push_back(model_encode(in_fmt, in_oper, in_dst, in_func, in_src, in_imm));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_f(input logic [1:0] f, input logic [3:0] op, input logic [3:0] d,
                          input logic [3:0] fn, input logic [3:0] s, input logic [7:0] im);
        in_valid = 1; in_fmt = f; in_oper = op; in_dst = d; in_func = fn; in_src = s; in_imm = im;
        tick();
        in_valid = 0;
    endtask

    task automatic pulse();
        pc_advance = 1;
        tick();
        pc_advance = 0;
    endtask

    task automatic test_reset();
        rst = 0; in_valid = 0; in_fmt = 0; in_oper = 0; in_dst = 0; in_func = 0; in_src = 0;
        in_imm = 0; inj_mode = 0; pc_advance = 0; mem_instr = 16'hD305;
        tick(); tick();
        rst = 1;
        tick();
        n_checks++; if (instr_out !== 16'hD305) begin n_fail++; $display("FAIL reset_instr_out got %h want d305", instr_out); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        n_checks++; if (inj_active !== 1'b0) begin n_fail++; $display("FAIL reset_inj_active got %b want 0", inj_active); end
        n_checks++; if (fmt_err !== 1'b0) begin n_fail++; $display("FAIL reset_fmt_err got %b want 0", fmt_err); end
`ifdef INJ_RETIRE_COUNT_EN
        n_checks++; if (retire_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_retire_cnt got %0d want 0", retire_cnt); end
`endif
    endtask

    task automatic test_basic_inject();
        push_f(2'd0, 4'd0, 4'd3, 4'd5, 4'd4, 8'h00);
        n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL basic_level got %0d want 1", fifo_level); end
        inj_mode = 1;
        pulse();
        n_checks++; if (instr_out !== 16'h0354) begin n_fail++; $display("FAIL basic_inject got %h want 0354", instr_out); end
        n_checks++; if (inj_active !== 1'b1) begin n_fail++; $display("FAIL basic_active got %b want 1", inj_active); end
        for (int i = 0; i < 3; i++) begin
            mem_instr = 16'($urandom);
            tick();
            n_checks++; if (instr_out !== 16'h0354) begin n_fail++; $display("FAIL basic_hold%0d got %h want 0354", i, instr_out); end
        end
        pulse();
        n_checks++; if (instr_out !== 16'h0000) begin n_fail++; $display("FAIL basic_nop got %h want 0000", instr_out); end
    endtask

    task automatic test_encoding();
        push_f(2'd1, 4'd5, 4'd2, 4'd9, 4'd9, 8'hFF);
        push_f(2'd2, 4'd0, 4'd7, 4'd0, 4'd1, 8'h00);
        n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL enc_level got %0d want 2", fifo_level); end
        pulse();
        n_checks++; if (instr_out !== 16'h52FF) begin n_fail++; $display("FAIL enc_regimm got %h want 52ff", instr_out); end
        pulse();
        n_checks++; if (instr_out !== 16'h47D1) begin n_fail++; $display("FAIL enc_scond got %h want 47d1", instr_out); end
        pulse();
        n_checks++; if (instr_out !== 16'h0000) begin n_fail++; $display("FAIL enc_drained got %h want 0000", instr_out); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 5; i++) begin
            push_f(2'd1, 4'(i), 4'(i), 4'd0, 4'd0, 8'(i));
            n_checks++;
            if (in_ready !== (i < 4)) begin n_fail++; $display("FAIL full_ready%0d got %b want %b", i, in_ready, (i < 4)); end
            n_checks++;
            if (fifo_level !== 3'((i < 4) ? i : 4)) begin n_fail++; $display("FAIL full_level%0d got %0d", i, fifo_level); end
        end
        pulse();
        n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL full_pop_level got %0d want 3", fifo_level); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready got %b want 1", in_ready); end
        n_checks++; if (instr_out !== 16'h1101) begin n_fail++; $display("FAIL full_pop_word got %h want 1101", instr_out); end
        pc_advance = 1;
        push_f(2'd0, 4'hA, 4'hB, 4'hC, 4'hD, 8'h00);
        pc_advance = 0;
        n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL full_pushpop_level got %0d want 3", fifo_level); end
        n_checks++; if (instr_out !== 16'h2202) begin n_fail++; $display("FAIL full_pushpop_word got %h want 2202", instr_out); end
        pulse(); pulse();
        pulse();
        n_checks++; if (instr_out !== 16'hABCD) begin n_fail++; $display("FAIL full_last_word got %h want abcd", instr_out); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL full_drain_level got %0d want 0", fifo_level); end
    endtask

    task automatic test_reserved();
        push_f(2'd3, 4'hF, 4'hF, 4'hF, 4'hF, 8'hFF);
        n_checks++; if (fmt_err !== 1'b1) begin n_fail++; $display("FAIL rsv_err got %b want 1", fmt_err); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rsv_level got %0d want 0", fifo_level); end
        push_f(2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 8'h00);
        n_checks++; if (fmt_err !== 1'b1) begin n_fail++; $display("FAIL rsv_sticky got %b want 1", fmt_err); end
        inj_mode = 1;
        pulse();
        n_checks++; if (instr_out !== 16'h1234) begin n_fail++; $display("FAIL rsv_word got %h want 1234", instr_out); end
        inj_mode = 0;
        mem_instr = 16'hBEEF;
        tick(); tick();
        n_checks++; if (instr_out !== 16'h1234) begin n_fail++; $display("FAIL toggle_hold got %h want 1234", instr_out); end
        pulse();
        n_checks++; if (instr_out !== 16'hBEEF) begin n_fail++; $display("FAIL toggle_pass got %h want beef", instr_out); end
        n_checks++; if (inj_active !== 1'b0) begin n_fail++; $display("FAIL toggle_active got %b want 0", inj_active); end
    endtask

    task automatic test_reset_mid();
        push_f(2'd0, 4'd1, 4'd1, 4'd1, 4'd1, 8'h00);
        push_f(2'd0, 4'd2, 4'd2, 4'd2, 4'd2, 8'h00);
        push_f(2'd0, 4'd3, 4'd3, 4'd3, 4'd3, 8'h00);
        inj_mode = 1;
        pulse();
        push_f(2'd0, 4'd4, 4'd4, 4'd4, 4'd4, 8'h00);
        n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL mid_level got %0d want 3", fifo_level); end
        mem_instr = 16'h5A5A;
        rst = 0; tick(); rst = 1;
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_rst_level got %0d want 0", fifo_level); end
        n_checks++; if (instr_out !== 16'h5A5A) begin n_fail++; $display("FAIL mid_rst_out got %h want 5a5a", instr_out); end
        n_checks++; if (fmt_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %b want 0", fmt_err); end
`ifdef INJ_RETIRE_COUNT_EN
        n_checks++; if (retire_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d want 0", retire_cnt); end
        push_f(2'd1, 4'd7, 4'd7, 4'd0, 4'd0, 8'h07);
        push_f(2'd1, 4'd8, 4'd8, 4'd0, 4'd0, 8'h08);
        pulse(); pulse(); pulse();
        n_checks++; if (retire_cnt !== 16'd2) begin n_fail++; $display("FAIL retire_cnt got %0d want 2", retire_cnt); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 99) != 0);
            in_valid   = ($urandom_range(0, 1) == 1);
            in_fmt     = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            in_oper    = 4'($urandom); in_dst = 4'($urandom);
            in_func    = 4'($urandom); in_src = 4'($urandom);
            in_imm     = 8'($urandom);
            inj_mode   = ($urandom_range(0, 3) != 0);
            pc_advance = ($urandom_range(0, 2) == 0);
            mem_instr  = 16'($urandom);
            tick();
            n_checks++;
            if (instr_out !== (m_mode ? m_cur : mem_instr)) begin
                n_fail++; $display("FAIL rnd_instr_out cyc %0d got %h want %h", i, instr_out, m_mode ? m_cur : mem_instr);
            end
            n_checks++;
            if (fifo_level !== 3'(m_q.size()) || in_ready !== (m_q.size() != DEPTH)) begin
                n_fail++; $display("FAIL rnd_level cyc %0d got %0d/%b want %0d", i, fifo_level, in_ready, m_q.size());
            end
            n_checks++;
            if (inj_active !== m_mode || fmt_err !== m_err) begin
                n_fail++; $display("FAIL rnd_flags cyc %0d got %b%b want %b%b", i, inj_active, fmt_err, m_mode, m_err);
            end
`ifdef INJ_RETIRE_COUNT_EN
            n_checks++;
            if (retire_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, retire_cnt, m_cnt); end
`endif
        end
        rst = 1; in_valid = 0; pc_advance = 0;
    endtask

    initial begin
        test_reset();
        test_basic_inject();
        test_encoding();
        test_full();
        test_reserved();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_injector.md
Name: instr_injector

Overview:
- Encoder-side counterpart to the core's instruction decoder/controller.
- Takes instruction fields from a debug/host port, packs them into 16-bit ISA words, and buffers them in a small FIFO.
- Drives them onto the core's instruction bus one per instruction boundary, marked by the core's pcwrite pulse.
- When injection is off, memory instructions pass straight through.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  host field set valid
- in_ready  out  1  FIFO can accept (= !full)
- in_fmt  in  2  00 reg-reg, 01 reg-imm, 10 scond, 11 reserved
- in_oper  in  4  opcode [15:12]
- in_dst  in  4  dst/cond field [11:8]
- in_func  in  4  func [7:4] (fmt 00)
- in_src  in  4  src [3:0] (fmt 00), cond (fmt 10)
- in_imm  in  8  immediate/displacement (fmt 01)
- inj_mode  in  1  request injection (1) or memory pass-through (0)
- mem_instr  in  16  instruction from program memory
- pc_advance  in  1  core pcwrite; one pulse per retired instruction
- instr_out  out  16  instruction to core
- fifo_level  out  ADDR_W+1  entries queued
- inj_active  out  1  registered mode currently in effect
- fmt_err  out  1  sticky: reserved format received

Behaviour:
- Encoding, applied at push:
  - fmt 00: {oper,dst,func,src}
  - fmt 01: {oper,dst,imm}
  - fmt 10: {4'b0100,dst,4'b1101,src}
  - fmt 11: handshake completes, word dropped, fmt_err<=1.
- Push happens when in_valid && in_ready.
- in_ready = level != DEPTH. There is no push at full.
- Registers: mode_q, cur[15:0], FIFO storage/pointers, fmt_err.
- Reset values: mode_q=0, cur=16'h0000, FIFO empty (level 0, in_ready=1), fmt_err=0. Therefore instr_out = mem_instr after reset.
- instr_out = mode_q ? cur : mem_instr, combinational mux only.
- On each cycle with pc_advance=1:
  - mode_q<=inj_mode.
  - If inj_mode=1 and FIFO non-empty: cur<=head, pop.
  - If inj_mode=1 and FIFO empty: cur<=16'h0000 (NOP: reg-op, func 0, no regwrite).
  - If inj_mode=0: no pop, cur<=16'h0000.
- Without pc_advance, cur and mode_q hold. instr_out never changes mid-instruction in inject mode, whether the instruction takes 2 cycles or 3 (load).
- Toggling inj_mode between pulses has no effect until the next pulse.
- Simultaneous push and pop (level not full): both occur, level unchanged.
- Push into an empty FIFO on a pc_advance cycle: no bypass. The word is popped at the following pulse; cur gets NOP this time.
- Pointers wrap modulo DEPTH. Level is tracked separately, so full and empty are unambiguous.
- Reset mid-operation discards FIFO contents and cur and returns to pass-through. fmt_err clears only on reset.

Optional Feature:
- Macro INJ_RETIRE_COUNT_EN.
- When defined:
  - Adds port retire_cnt out 16.
  - Counts pulses that popped a FIFO word.
  - Resets to 0 and wraps 16'hFFFF->0.
- When undefined: no port and no counter logic.

Decomposition:
- Shared package cr16_isa_pkg holds:
  - opcode constants (REGISTER, SPECIAL, BCOND, ...) and special func codes (LOAD, STOR, JAL, JCOND, SCOND).
  - fmt encoding constants.
  - NOP_INSTR = 16'h0000.
- Sub-module: inj_fifo (parameterised DEPTH/ADDR_W, 16-bit, push/pop/level/full/empty).
- Encoding and mode/cur logic stay in instr_injector.

Test Plan:
- Reset, then mem_instr=16'hD305, inj_mode=0 -> instr_out=16'hD305, in_ready=1, fifo_level=0, inj_active=0.
- Push fmt00 oper=0 dst=3 func=5 src=4; inj_mode=1; pulse pc_advance:
  - instr_out=16'h0354 from the next cycle, held for 3 cycles without a pulse.
  - Next pulse with empty FIFO -> 16'h0000.
- Encoding checks:
  - Push fmt01 oper=5 dst=2 imm=8'hFF -> 16'h52FF.
  - Push fmt10 dst=7 src=1 -> 16'h47D1.
  - Both emitted in order on consecutive pulses.
- Fullness:
  - 5 pushes with no pulses -> in_ready=0 after the 4th, level=4, 5th not accepted.
  - One pulse -> level=3, in_ready=1.
  - Push and pulse in the same cycle -> level stays 3.
- Reserved format:
  - fmt11 push -> fmt_err=1 and stays 1, level unchanged.
  - Toggle inj_mode 1->0 between pulses -> instr_out holds cur until the pulse, then equals mem_instr.
- Reset mid-operation:
  - Assert rst with 3 entries queued -> level=0, instr_out=mem_instr.
  - With INJ_RETIRE_COUNT_EN, retire_cnt=0 after reset and counts 2 after two popping pulses.
